// File: rtl/bru_pkg.sv
// Shared types and constants for the EX-stage branch resolve unit.
package bru_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;
  localparam int INSTR_BYTES = 4;

  // x1 (ra) and x5 (t0) are the link registers for call/return hints.
  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

endpackage

// File: rtl/bru_link_classify.sv
// Classifies JAL/JALR as call, return or plain jump from link-register usage.
module bru_link_classify
  import bru_pkg::*;
(
  input  logic       jal,
  input  logic       jalr,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  output logic       call,
  output logic       ret,
  output logic       jump
);

  logic rd_link;
  logic rs1_link;

  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  assign call = (jal | jalr) & rd_link;
  assign ret  = jalr & rs1_link & ~rd_link;
  assign jump = (jal | jalr) & ~call & ~ret;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: predictor training, redirect and IF/ID flush.
// Optional BRU_PERF_CNT_EN adds saturating branch/miss counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       ex_rs1,
  input  logic             ex_cond_true,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_pc,
  input  logic             ctrl_stall,
  output logic             branch_ex_req,
  output logic [WIDTH-1:0] branch_ex_pc,
  output logic             branch_ex_taken,
  output logic             branch_ex_jump,
  output logic             branch_ex_call,
  output logic             branch_ex_ret,
  output logic [WIDTH-1:0] branch_ex_next_pc,
  output logic             branch_miss,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush_if_id
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_misses
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic             cls_call;
  logic             cls_ret;
  logic             cls_jump;
  logic             ctl;
  logic             fire;
  logic             act_taken;
  logic [WIDTH-1:0] act_next;
  logic             miss;

  state_e           state_q,    state_d;
  logic [3:0]       cnt_q,      cnt_d;
  logic             flush_q,    flush_d;
  logic             req_q,      req_d;
  logic [WIDTH-1:0] pc_q,       pc_d;
  logic             taken_q,    taken_d;
  logic             jump_q,     jump_d;
  logic             call_q,     call_d;
  logic             ret_q,      ret_d;
  logic [WIDTH-1:0] next_pc_q,  next_pc_d;
  logic             miss_q,     miss_d;
  logic [WIDTH-1:0] rpc_q,      rpc_d;

  bru_link_classify u_classify (
    .jal  (ex_is_jal),
    .jalr (ex_is_jalr),
    .rd   (ex_rd),
    .rs1  (ex_rs1),
    .call (cls_call),
    .ret  (cls_ret),
    .jump (cls_jump)
  );

  always_comb begin
    ctl       = ex_is_branch | ex_is_jal | ex_is_jalr;
    fire      = ex_valid & ~ctrl_stall & (state_q == S_IDLE);
    act_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_cond_true);
    if (act_taken)
      act_next = ex_is_jalr ? {ex_target[WIDTH-1:1], 1'b0} : ex_target;
    else
      act_next = ex_pc + WIDTH'(INSTR_BYTES);
    // Non-control instructions still miss when a BTB alias predicted taken.
    miss = fire & ((ex_pred_taken != act_taken) | (ex_pred_pc != act_next));

    req_d     = fire & ctl;
    pc_d      = pc_q;
    taken_d   = taken_q;
    jump_d    = jump_q;
    call_d    = call_q;
    ret_d     = ret_q;
    next_pc_d = next_pc_q;
    if (fire && ctl) begin
      pc_d      = ex_pc;
      taken_d   = act_taken;
      jump_d    = cls_jump;
      call_d    = cls_call;
      ret_d     = cls_ret;
      next_pc_d = act_next;
    end
    miss_d = miss;
    rpc_d  = miss ? act_next : rpc_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
          flush_d = 1'b1;
        end
      end
      S_FLUSH: begin
        // Counts down through stalls too; wrong-path EX contents are ignored.
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      flush_q   <= 1'b0;
      req_q     <= 1'b0;
      pc_q      <= '0;
      taken_q   <= 1'b0;
      jump_q    <= 1'b0;
      call_q    <= 1'b0;
      ret_q     <= 1'b0;
      next_pc_q <= '0;
      miss_q    <= 1'b0;
      rpc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      req_q     <= req_d;
      pc_q      <= pc_d;
      taken_q   <= taken_d;
      jump_q    <= jump_d;
      call_q    <= call_d;
      ret_q     <= ret_d;
      next_pc_q <= next_pc_d;
      miss_q    <= miss_d;
      rpc_q     <= rpc_d;
    end
  end

  assign branch_ex_req     = req_q;
  assign branch_ex_pc      = pc_q;
  assign branch_ex_taken   = taken_q;
  assign branch_ex_jump    = jump_q;
  assign branch_ex_call    = call_q;
  assign branch_ex_ret     = ret_q;
  assign branch_ex_next_pc = next_pc_q;
  assign branch_miss       = miss_q;
  assign redirect_valid    = miss_q;
  assign redirect_pc       = rpc_q;
  assign flush_if_id       = flush_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q,   perf_br_d;
  logic [31:0] perf_miss_q, perf_miss_d;

  always_comb begin
    perf_br_d   = perf_br_q;
    perf_miss_d = perf_miss_q;
    if (req_d && perf_br_q != 32'hFFFF_FFFF)
      perf_br_d = perf_br_q + 32'd1;
    if (miss_d && perf_miss_q != 32'hFFFF_FFFF)
      perf_miss_d = perf_miss_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q   <= 32'd0;
      perf_miss_q <= 32'd0;
    end else begin
      perf_br_q   <= perf_br_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_misses   = perf_miss_q;
`endif

  a_ctl_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    ex_valid |-> $onehot0({ex_is_branch, ex_is_jal, ex_is_jalr}));

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed plan cases then random traffic.
module tb_branch_resolve_unit;

  localparam int W  = 32;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0;
  logic [W-1:0]  ex_pc = '0;
  logic          ex_is_branch = 1'b0;
  logic          ex_is_jal = 1'b0;
  logic          ex_is_jalr = 1'b0;
  logic [4:0]    ex_rd = '0;
  logic [4:0]    ex_rs1 = '0;
  logic          ex_cond_true = 1'b0;
  logic [W-1:0]  ex_target = '0;
  logic          ex_pred_taken = 1'b0;
  logic [W-1:0]  ex_pred_pc = '0;
  logic          ctrl_stall = 1'b0;
  logic          branch_ex_req;
  logic [W-1:0]  branch_ex_pc;
  logic          branch_ex_taken;
  logic          branch_ex_jump;
  logic          branch_ex_call;
  logic          branch_ex_ret;
  logic [W-1:0]  branch_ex_next_pc;
  logic          branch_miss;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          flush_if_id;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]   perf_branches;
  logic [31:0]   perf_misses;
`endif

  branch_resolve_unit #(.WIDTH(W), .FLUSH_CYCLES(FC)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid          (ex_valid),
    .ex_pc             (ex_pc),
    .ex_is_branch      (ex_is_branch),
    .ex_is_jal         (ex_is_jal),
    .ex_is_jalr        (ex_is_jalr),
    .ex_rd             (ex_rd),
    .ex_rs1            (ex_rs1),
    .ex_cond_true      (ex_cond_true),
    .ex_target         (ex_target),
    .ex_pred_taken     (ex_pred_taken),
    .ex_pred_pc        (ex_pred_pc),
    .ctrl_stall        (ctrl_stall),
    .branch_ex_req     (branch_ex_req),
    .branch_ex_pc      (branch_ex_pc),
    .branch_ex_taken   (branch_ex_taken),
    .branch_ex_jump    (branch_ex_jump),
    .branch_ex_call    (branch_ex_call),
    .branch_ex_ret     (branch_ex_ret),
    .branch_ex_next_pc (branch_ex_next_pc),
    .branch_miss       (branch_miss),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .flush_if_id       (flush_if_id)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches     (perf_branches),
    .perf_misses       (perf_misses)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    bit          req;
    bit [31:0]   pc;
    bit          taken;
    bit          jump;
    bit          call;
    bit          ret;
    bit [31:0]   next_pc;
    bit          miss;
    bit [31:0]   rpc;
  } exp_t;

  exp_t        expq[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  // Reference state: slots blocked after a miss, and the last trained payload.
  int          blocked = 0;
  bit [31:0]   m_pc = 0, m_next = 0, m_rpc = 0;
  bit          m_taken = 0, m_jump = 0, m_call = 0, m_ret = 0;
  int          m_nbr = 0, m_nmiss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_link(input bit [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic drive(input bit v, input bit [31:0] pc, input bit br, input bit jal,
                       input bit jalr, input bit [4:0] rd, input bit [4:0] rs1,
                       input bit cond, input bit [31:0] tgt, input bit pt,
                       input bit [31:0] ppc, input bit stall);
    bit fire, ctl, taken, miss;
    bit [31:0] nxt;
    exp_t e;
    @(negedge clk);
    ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_rd = rd; ex_rs1 = rs1; ex_cond_true = cond; ex_target = tgt;
    ex_pred_taken = pt; ex_pred_pc = ppc; ctrl_stall = stall;
    fire = v && !stall && (blocked == 0);
    if (blocked > 0) blocked--;
    if (fire) begin
      ctl   = br || jal || jalr;
      taken = jal || jalr || (br && cond);
      nxt   = taken ? (jalr ? (tgt & 32'hFFFF_FFFE) : tgt) : pc + 32'd4;
      miss  = (pt != taken) || (ppc != nxt);
      if (ctl) begin
        m_pc = pc; m_taken = taken; m_next = nxt;
        m_call = (jal || jalr) && is_link(rd);
        m_ret  = jalr && is_link(rs1) && !is_link(rd);
        m_jump = (jal || jalr) && !m_call && !m_ret;
        m_nbr++;
      end
      if (miss) begin
        m_rpc = nxt;
        blocked = FC;
        m_nmiss++;
      end
      if (ctl || miss) begin
        e.cyc = cyc + 1; e.req = ctl; e.pc = m_pc; e.taken = m_taken; e.jump = m_jump;
        e.call = m_call; e.ret = m_ret; e.next_pc = m_next; e.miss = miss; e.rpc = m_rpc;
        expq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_flush_if_id", flush_if_id, 0);
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_branch_ex_req", branch_ex_req, 0);
    end
    expq.delete();
    blocked = 0;
    m_pc = 0; m_next = 0; m_rpc = 0;
    m_taken = 0; m_jump = 0; m_call = 0; m_ret = 0;
    m_nbr = 0; m_nmiss = 0;
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops the expected record whenever the DUT presents a transaction.
  int run = 0;
  bit prev_flush = 0;
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (!rst_n) begin
      run = 0;
      prev_flush = 0;
    end else begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        errors++; checks++;
        $display("FAIL missing_txn: got none expected txn for cycle %0d (pc 0x%0h)", expq[0].cyc, expq[0].pc);
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        $display("txn cyc=%0d req=%0b pc=0x%08h taken=%0b next=0x%08h miss=%0b rpc=0x%08h",
                 cyc, branch_ex_req, branch_ex_pc, branch_ex_taken, branch_ex_next_pc,
                 branch_miss, redirect_pc);
        chk("branch_ex_req", branch_ex_req, e.req);
        chk("branch_miss", branch_miss, e.miss);
        chk("redirect_valid", redirect_valid, e.miss);
        chk("branch_ex_pc", branch_ex_pc, e.pc);
        chk("branch_ex_taken", branch_ex_taken, e.taken);
        chk("branch_ex_jump", branch_ex_jump, e.jump);
        chk("branch_ex_call", branch_ex_call, e.call);
        chk("branch_ex_ret", branch_ex_ret, e.ret);
        chk("branch_ex_next_pc", branch_ex_next_pc, e.next_pc);
        chk("redirect_pc", redirect_pc, e.rpc);
      end else if (branch_ex_req || branch_miss || redirect_valid) begin
        errors++; checks++;
        $display("FAIL spurious_txn: got req=%0b miss=%0b redir=%0b expected none (cycle %0d)",
                 branch_ex_req, branch_miss, redirect_valid, cyc);
      end
      if (flush_if_id && !prev_flush) chk("flush_starts_with_redirect", redirect_valid, 1);
      if (flush_if_id) run++;
      if (!flush_if_id && prev_flush) begin
        chk("flush_length", run, FC);
        run = 0;
      end
      prev_flush = flush_if_id;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] pc, tgt, ppc, nxt;
    bit br, jal, jalr, cond, pt, tk;
    bit [4:0] rd, rs1;
    int k;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_flush_if_id", flush_if_id, 0);
    chk("reset_branch_ex_req", branch_ex_req, 0);
    chk("reset_branch_miss", branch_miss, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_next_pc", branch_ex_next_pc, 0);
    rst_n = 1'b1;
    idle(2);

    // Correctly predicted taken branch.
    drive(1, 32'h100, 1, 0, 0, 0, 0, 1, 32'h140, 1, 32'h140, 0);
    idle(3);
    // Same branch not taken: miss, redirect to fall-through, valid branches during flush.
    drive(1, 32'h100, 1, 0, 0, 0, 0, 0, 32'h140, 1, 32'h140, 0);
    for (int i = 0; i < 4; i++)
      drive(1, 32'h180, 1, 0, 0, 0, 0, 1, 32'h1C0, 1, 32'h1C0, 0);
    idle(4);
    // Call via JAL predicted not taken, then return via JALR with odd target.
    drive(1, 32'h200, 0, 1, 0, 5'd1, 5'd0, 0, 32'h300, 0, 32'h204, 0);
    idle(4);
    drive(1, 32'h300, 0, 0, 1, 5'd0, 5'd1, 0, 32'h205, 1, 32'h204, 0);
    idle(2);
    // Stalled branch trains once, after release.
    for (int i = 0; i < 3; i++)
      drive(1, 32'h400, 1, 0, 0, 0, 0, 1, 32'h480, 1, 32'h480, 1);
    drive(1, 32'h400, 1, 0, 0, 0, 0, 1, 32'h480, 1, 32'h480, 0);
    idle(3);
    // Non-control alias at top of address space: fall-through wraps to 0.
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h80, 1, 32'h80, 0);
    idle(5);
    // Reset mid-flush.
    drive(1, 32'h500, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h600, 0);
    do_reset(1);
    idle(2);

    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 3);
      br = (k == 1); jal = (k == 2); jalr = (k == 3);
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      tgt = $urandom;
      cond = $urandom_range(0, 1);
      k = $urandom_range(0, 3);
      rd  = (k == 0) ? 5'd1 : (k == 1) ? 5'd5 : 5'(k == 2 ? 0 : $urandom_range(0, 31));
      k = $urandom_range(0, 3);
      rs1 = (k == 0) ? 5'd1 : (k == 1) ? 5'd5 : 5'(k == 2 ? 0 : $urandom_range(0, 31));
      tk  = jal || jalr || (br && cond);
      nxt = tk ? (jalr ? (tgt & 32'hFFFF_FFFE) : tgt) : pc + 32'd4;
      if ($urandom_range(0, 1) == 1) begin
        pt = tk; ppc = nxt;
      end else begin
        pt = $urandom_range(0, 1);
        ppc = ($urandom_range(0, 1) == 1) ? pc + 32'd4 : tgt;
      end
      drive($urandom_range(0, 3) != 0, pc, br, jal, jalr, rd, rs1, cond, tgt, pt, ppc,
            $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) do_reset(0);
    end
    idle(FC + 4);
    chk("queue_drained", expq.size(), 0);
    chk("final_flush_if_id", flush_if_id, 0);
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches", perf_branches, m_nbr);
    chk("perf_misses", perf_misses, m_nmiss);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
